// File: rtl/sifive_insight_tlb_probe_capture_if.sv
// Snooped TileLink B-channel beats in, timestamped trace records out, plus
// the capture enable and the drop/occupancy status seen by the trace sink.
interface sifive_insight_tlb_probe_capture_if #(
  parameter int DEPTH  = 4,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              enable;
  logic              b_ready;
  logic              b_valid;
  logic [2:0]        b_opcode;
  logic [1:0]        b_param;
  logic [3:0]        b_size;
  logic              b_source;
  logic [31:0]       b_address;
  logic              rec_valid;
  logic              rec_ready;
  logic [2:0]        rec_opcode;
  logic [1:0]        rec_param;
  logic [3:0]        rec_size;
  logic              rec_source;
  logic [31:0]       rec_address;
  logic [TS_W-1:0]   rec_timestamp;
  logic              rec_gap;
  logic [DROP_W-1:0] drop_count;
  logic [LW-1:0]     fifo_level;

  modport master (
    output enable, b_ready, b_valid, b_opcode, b_param, b_size, b_source, b_address, rec_ready,
    input  rec_valid, rec_opcode, rec_param, rec_size, rec_source, rec_address,
           rec_timestamp, rec_gap, drop_count, fifo_level
  );

  modport slave (
    input  enable, b_ready, b_valid, b_opcode, b_param, b_size, b_source, b_address, rec_ready,
    output rec_valid, rec_opcode, rec_param, rec_size, rec_source, rec_address,
           rec_timestamp, rec_gap, drop_count, fifo_level
  );
endinterface

// File: rtl/sifive_insight_tlb_probe_capture.sv
// Passive B-channel probe capture: timestamps each fired beat, buffers it in a
// small FIFO for the Insight trace sink and counts records lost to overflow.
module sifive_insight_tlb_probe_capture #(
  parameter int DEPTH  = 4,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input logic clock,
  input logic reset,
  sifive_insight_tlb_probe_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [2:0]      opcode;
    logic [1:0]      param;
    logic [3:0]      size;
    logic            source;
    logic [31:0]     address;
    logic [TS_W-1:0] timestamp;
    logic            gap;
  } rec_t;

  function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rec_t              mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic [LW-1:0]     level;
  logic [TS_W-1:0]   ts;
  logic [DROP_W-1:0] dropCount;
  logic              gapPending;
  logic              recValid;
  logic              cap;
  logic              pop;
  logic              push;
  logic              full;

  assign recValid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign cap      = bus.enable & bus.b_valid & bus.b_ready;
  assign pop      = recValid & bus.rec_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push     = cap & (~full | pop);

  // Capture stage boundary: control state (reset applies here only)
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      level      <= '0;
      ts         <= '0;
      dropCount  <= '0;
      gapPending <= 1'b0;
    end else begin
      ts    <= ts + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push) begin
        gapPending <= 1'b0;
      end else if (cap) begin
        gapPending <= 1'b1;
        dropCount  <= satInc(dropCount);
      end
    end
  end

  // Record storage boundary: data only, qualified by push
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtr] <= '{opcode:    bus.b_opcode,
                      param:     bus.b_param,
                      size:      bus.b_size,
                      source:    bus.b_source,
                      address:   bus.b_address,
                      timestamp: ts,
                      gap:       gapPending};
    end
  end

  assign bus.rec_valid     = recValid;
  assign bus.rec_opcode    = mem[rdPtr].opcode;
  assign bus.rec_param     = mem[rdPtr].param;
  assign bus.rec_size      = mem[rdPtr].size;
  assign bus.rec_source    = mem[rdPtr].source;
  assign bus.rec_address   = mem[rdPtr].address;
  assign bus.rec_timestamp = mem[rdPtr].timestamp;
  assign bus.rec_gap       = mem[rdPtr].gap;
  assign bus.drop_count    = dropCount;
  assign bus.fifo_level    = level;
endmodule

// File: tb/tb_sifive_insight_tlb_probe_capture.sv
// Bench for the probe capture block: a default instance plus a narrow one
// (DEPTH=2, TS_W=4, DROP_W=2), both checked every cycle against a queue model.
module tb_sifive_insight_tlb_probe_capture;
  logic clock;
  logic reset;
  int   nAsserts;
  int   nFails;

  sifive_insight_tlb_probe_capture_if #(.DEPTH(4), .TS_W(16), .DROP_W(8)) bi0 ();
  sifive_insight_tlb_probe_capture_if #(.DEPTH(2), .TS_W(4),  .DROP_W(2)) bi1 ();

  sifive_insight_tlb_probe_capture #(.DEPTH(4), .TS_W(16), .DROP_W(8)) dut0 (
    .clock(clock), .reset(reset), .bus(bi0));
  sifive_insight_tlb_probe_capture #(.DEPTH(2), .TS_W(4), .DROP_W(2)) dut1 (
    .clock(clock), .reset(reset), .bus(bi1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned op, param, size, src, addr, ts, gap;
  } mrec_t;

  mrec_t mq [2][$];
  int    mDepth   [2] = '{4, 2};
  int    mTsMod   [2] = '{65536, 16};
  int    mDropMax [2] = '{255, 3};
  int    mTs      [2];
  int    mDrop    [2];
  int    mGap     [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input int id);
    int unsigned en, bv, br, rdy;
    mrec_t r;
    bit cap, pop, push;
    if (id == 0) begin
      en = bi0.enable; bv = bi0.b_valid; br = bi0.b_ready; rdy = bi0.rec_ready;
      r.op = bi0.b_opcode; r.param = bi0.b_param; r.size = bi0.b_size;
      r.src = bi0.b_source; r.addr = bi0.b_address;
    end else begin
      en = bi1.enable; bv = bi1.b_valid; br = bi1.b_ready; rdy = bi1.rec_ready;
      r.op = bi1.b_opcode; r.param = bi1.b_param; r.size = bi1.b_size;
      r.src = bi1.b_source; r.addr = bi1.b_address;
    end
    if (reset) begin
      mq[id].delete();
      mTs[id] = 0; mDrop[id] = 0; mGap[id] = 0;
      return;
    end
    cap  = (en != 0) && (bv != 0) && (br != 0);
    pop  = (mq[id].size() > 0) && (rdy != 0);
    push = cap && ((mq[id].size() < mDepth[id]) || pop);
    if (pop) void'(mq[id].pop_front());
    if (push) begin
      r.ts = mTs[id]; r.gap = mGap[id];
      mq[id].push_back(r);
      mGap[id] = 0;
    end else if (cap) begin
      if (mDrop[id] < mDropMax[id]) mDrop[id]++;
      mGap[id] = 1;
    end
    mTs[id] = (mTs[id] + 1) % mTsMod[id];
  endtask

  task automatic checkDut(input int id);
    logic v, gap, src;
    logic [63:0] op, param, size, addr, ts, drop, lvl;
    if (id == 0) begin
      v = bi0.rec_valid; gap = bi0.rec_gap; src = bi0.rec_source;
      op = 64'(bi0.rec_opcode); param = 64'(bi0.rec_param); size = 64'(bi0.rec_size);
      addr = 64'(bi0.rec_address); ts = 64'(bi0.rec_timestamp);
      drop = 64'(bi0.drop_count); lvl = 64'(bi0.fifo_level);
    end else begin
      v = bi1.rec_valid; gap = bi1.rec_gap; src = bi1.rec_source;
      op = 64'(bi1.rec_opcode); param = 64'(bi1.rec_param); size = 64'(bi1.rec_size);
      addr = 64'(bi1.rec_address); ts = 64'(bi1.rec_timestamp);
      drop = 64'(bi1.drop_count); lvl = 64'(bi1.fifo_level);
    end
    chk($sformatf("d%0d.rec_valid", id), 64'(v), 64'(mq[id].size() != 0));
    chk($sformatf("d%0d.fifo_level", id), lvl, 64'(mq[id].size()));
    chk($sformatf("d%0d.drop_count", id), drop, 64'(mDrop[id]));
    if (mq[id].size() != 0) begin
      chk($sformatf("d%0d.rec_opcode", id), op, 64'(mq[id][0].op));
      chk($sformatf("d%0d.rec_param", id), param, 64'(mq[id][0].param));
      chk($sformatf("d%0d.rec_size", id), size, 64'(mq[id][0].size));
      chk($sformatf("d%0d.rec_source", id), 64'(src), 64'(mq[id][0].src));
      chk($sformatf("d%0d.rec_address", id), addr, 64'(mq[id][0].addr));
      chk($sformatf("d%0d.rec_timestamp", id), ts, 64'(mq[id][0].ts));
      chk($sformatf("d%0d.rec_gap", id), 64'(gap), 64'(mq[id][0].gap));
    end
  endtask

  task automatic tick();
    modelStep(0);
    modelStep(1);
    @(posedge clock);
    #1;
    checkDut(0);
    checkDut(1);
  endtask

  task automatic drive0(input logic en, input logic cap, input logic [2:0] op,
                        input logic [1:0] param, input logic [31:0] addr, input logic rdy);
    bi0.enable = en; bi0.b_valid = cap; bi0.b_ready = cap;
    bi0.b_opcode = op; bi0.b_param = param; bi0.b_size = 4'd6;
    bi0.b_source = addr[6]; bi0.b_address = addr; bi0.rec_ready = rdy;
  endtask

  task automatic drive1(input logic cap, input logic [31:0] addr, input logic rdy);
    bi1.enable = 1'b1; bi1.b_valid = cap; bi1.b_ready = cap;
    bi1.b_opcode = 3'd6; bi1.b_param = 2'd2; bi1.b_size = 4'd3;
    bi1.b_source = addr[4]; bi1.b_address = addr; bi1.rec_ready = rdy;
  endtask

  initial begin
    int tA;
    nAsserts = 0;
    nFails   = 0;
    drive0(1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    bi1.enable = 1'b0; drive1(1'b0, 32'h0, 1'b0); bi1.enable = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    tick();
    reset = 1'b0;
    chk("reset.rec_valid", 64'(bi0.rec_valid), 64'd0);
    chk("reset.fifo_level", 64'(bi0.fifo_level), 64'd0);
    chk("reset.drop_count", 64'(bi0.drop_count), 64'd0);

    // single probe at ts = 5
    drive0(1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    drive0(1'b1, 1'b1, 3'd6, 2'd1, 32'h8000_0040, 1'b1);
    tick();
    chk("single.rec_valid", 64'(bi0.rec_valid), 64'd1);
    chk("single.rec_timestamp", 64'(bi0.rec_timestamp), 64'd5);
    chk("single.rec_address", 64'(bi0.rec_address), 64'h8000_0040);
    chk("single.rec_opcode", 64'(bi0.rec_opcode), 64'd6);
    chk("single.rec_gap", 64'(bi0.rec_gap), 64'd0);
    drive0(1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    tick();
    chk("single.level_after_pop", 64'(bi0.fifo_level), 64'd0);

    // backpressure and ordering
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b1, 3'd6, 2'd0, 32'(i * 'h40), 1'b0);
      tick();
    end
    drive0(1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    tick(); tick();
    chk("bp.level", 64'(bi0.fifo_level), 64'd4);
    chk("bp.head_held", 64'(bi0.rec_address), 64'h0);
    drive0(1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("bp.order", 64'(bi0.rec_address), 64'(i * 'h40));
    end
    tick();
    chk("bp.drained", 64'(bi0.rec_valid), 64'd0);

    // overflow, gap flag, full with simultaneous pop/push
    for (int i = 0; i < 7; i++) begin
      drive0(1'b1, 1'b1, 3'd6, 2'd0, 32'h1000 + 32'(i * 'h40), 1'b0);
      tick();
    end
    chk("ovf.drop_count", 64'(bi0.drop_count), 64'd3);
    chk("ovf.level", 64'(bi0.fifo_level), 64'd4);
    drive0(1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    tick();
    drive0(1'b1, 1'b1, 3'd6, 2'd0, 32'h100, 1'b0);
    tick();
    drive0(1'b1, 1'b1, 3'd6, 2'd0, 32'h140, 1'b1);
    tick();
    chk("fullpp.level", 64'(bi0.fifo_level), 64'd4);
    chk("fullpp.drop_count", 64'(bi0.drop_count), 64'd3);
    drive0(1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    tick(); tick();
    chk("gap.after_drop_addr", 64'(bi0.rec_address), 64'h100);
    chk("gap.after_drop", 64'(bi0.rec_gap), 64'd1);
    tick();
    chk("gap.next_addr", 64'(bi0.rec_address), 64'h140);
    chk("gap.next", 64'(bi0.rec_gap), 64'd0);
    tick();

    // enable gating: ts keeps running
    tA = mTs[0];
    drive0(1'b1, 1'b1, 3'd6, 2'd3, 32'h200, 1'b0);
    tick();
    drive0(1'b0, 1'b1, 3'd6, 2'd3, 32'h220, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("gate.level", 64'(bi0.fifo_level), 64'd1);
    drive0(1'b1, 1'b1, 3'd6, 2'd3, 32'h240, 1'b0);
    tick();
    drive0(1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    tick();
    chk("gate.ts_advance", 64'(bi0.rec_timestamp), 64'((tA + 11) % 65536));
    tick();

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive0($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 3'($urandom),
             2'($urandom), $urandom, $urandom_range(0, 2) == 0);
      bi0.b_size = 4'($urandom);
      bi0.b_ready = $urandom_range(0, 4) != 0;
      reset = ($urandom_range(0, 99) == 0);
      tick();
      reset = 1'b0;
    end

    // narrow instance: drop saturation and timestamp wrap
    drive0(1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive1(1'b1, 32'h10 * 32'(i), 1'b0);
      tick();
    end
    chk("sat.drop_count", 64'(bi1.drop_count), 64'd3);
    chk("sat.level", 64'(bi1.fifo_level), 64'd2);
    drive1(1'b0, 32'h0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    drive1(1'b1, 32'hAA0, 1'b0);
    tick();
    drive1(1'b1, 32'hAB0, 1'b0);
    tick();
    chk("wrap.first_ts", 64'(bi1.rec_timestamp), 64'd15);
    drive1(1'b0, 32'h0, 1'b1);
    tick();
    chk("wrap.second_ts", 64'(bi1.rec_timestamp), 64'd0);
    chk("wrap.second_addr", 64'(bi1.rec_address), 64'hAB0);
    tick();

    // reset with two records buffered, cap active in the same cycle
    drive0(1'b1, 1'b1, 3'd6, 2'd0, 32'h300, 1'b0);
    tick(); tick();
    chk("rst.level_before", 64'(bi0.fifo_level), 64'd2);
    drive0(1'b1, 1'b1, 3'd6, 2'd0, 32'h340, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst.rec_valid", 64'(bi0.rec_valid), 64'd0);
    chk("rst.fifo_level", 64'(bi0.fifo_level), 64'd0);
    chk("rst.drop_count", 64'(bi0.drop_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
